// File: rtl/cola_pkg.sv
// Shared types and defaults for the destination-table sequencer.
package cola_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 24;
    localparam logic [DATA_W_DEF-1:0] END_MARK_DEF = '0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_e;

endpackage

// File: rtl/despachador_destinos.sv
// Walks the destination table from entry 0 and dispatches each non-terminator
// entry over valid/ready, stopping at the first END_MARK or the last entry.
module despachador_destinos
    import cola_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter logic [DATA_W-1:0] END_MARK = DATA_W'(END_MARK_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] destino,
    output logic              dest_valid,
    output logic [DATA_W-1:0] dest_data,
    input  logic              dest_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dest_data_q, dest_data_d;
    logic              dest_valid_q, dest_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            address_q    <= '0;
            count_q      <= '0;
            dest_data_q  <= '0;
            dest_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            count_q      <= count_d;
            dest_data_q  <= dest_data_d;
            dest_valid_q <= dest_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next state; status outputs are registered copies of the next state.
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        count_d     = count_q;
        dest_data_d = dest_data_q;

        unique case (state_q)
            IDLE: begin
                address_d = '0;
                if (start && !abort) begin
                    state_d = FETCH;
                    count_d = '0;
                end
            end
            FETCH: begin
                dest_data_d = destino;
                state_d     = (destino == END_MARK) ? DONE : PRESENT;
            end
            PRESENT: begin
                if (dest_ready) begin
                    count_d = count_q + CNT_W'(1);
                    if (address_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        address_d = address_q + ADDR_W'(1);
                        state_d   = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Cancel wins over any handshake in the same cycle; count is kept.
        if (state_q != IDLE && abort) begin
            state_d   = IDLE;
            address_d = '0;
            count_d   = count_q;
        end

        if (state_d == DONE) begin
            address_d = '0;
        end

        dest_valid_d = (state_d == PRESENT);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == DONE);
    end

    assign address    = address_q;
    assign dest_valid = dest_valid_q;
    assign dest_data  = dest_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign count      = count_q;

endmodule

// File: doc/despachador_destinos.md
# despachador_destinos

Sequencer directly downstream of the `cola_destinos_externos` lookup table. It walks the table's `address` input from entry 0 upward and reads each 24-bit `destino`. Each non-terminator entry is presented to the motion/execution stage over a valid/ready handshake. A run stops at the first all-zero entry or at the last table entry, and the block reports how many destinations it dispatched.

## Interface
Parameters:
- `ADDR_W`, 8, table address width.
- `DATA_W`, 24, destination word width.
- `END_MARK`, 24'd0, table value that terminates a list.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  pulse that begins a run; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; takes priority over everything except `rst`.
- `address`  out  ADDR_W  drives the table's address input; registered.
- `destino`  in  DATA_W  combinational table output for `address`.
- `dest_valid`  out  1  `dest_data` holds a dispatched destination.
- `dest_data`  out  DATA_W  registered destination word.
- `dest_ready`  in  1  consumer accepts `dest_data` when `dest_valid` is also high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at normal end of run.
- `count`  out  ADDR_W+1  destinations accepted in the current or last run.

## Operation
- States:
  - IDLE: `address`=0, outputs quiet. `start`=1 moves to FETCH and clears `count`.
  - FETCH: one cycle. `destino` is captured into `dest_data`.
    - `destino`==END_MARK moves to DONE.
    - Otherwise moves to PRESENT.
  - PRESENT: `dest_valid`=1 and `dest_data` is held stable until the handshake.
    - On `dest_valid & dest_ready`, `count` increments.
    - If `address`==2^ADDR_W−1, moves to DONE. The address never wraps.
    - Otherwise `address` increments and the state moves to FETCH.
  - DONE: one cycle. `done`=1 and `address` returns to 0. Moves to IDLE.
- `abort`=1 in any non-IDLE state:
  - next cycle is IDLE with `address`=0 and `dest_valid`=0;
  - `done` is not pulsed and `count` keeps its value.
- `start` outside IDLE is ignored. `abort` in IDLE is a no-op.
- `start` and `abort` high together in IDLE: stay in IDLE.
- `count` saturates naturally: at most 2^ADDR_W (256 by default), which fits ADDR_W+1 bits.
- `count` holds its value in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `address`=0, `dest_valid`=0, `dest_data`=0, `busy`=0, `done`=0, `count`=0.
- `rst` mid-run overrides `abort` and returns the block to reset values next cycle.
- Latency, with `start` sampled at cycle n:
  - FETCH at n+1;
  - `dest_valid`=1 at n+2.
- Handshake at cycle m moves to FETCH at m+1 with `address`+1. The next `dest_valid` rises at m+2.
- Peak throughput is one destination per 2 cycles.
- Terminator at address 0: `done` at n+2, `count`=0, `dest_valid` never asserted.
- `dest_ready` may be high before `dest_valid`; no combinational path exists from `dest_ready` to `dest_valid`.
- `busy` covers FETCH, PRESENT and DONE, including the `done` cycle.

## Structure
- Shared package `cola_pkg` holds:
  - state enum (IDLE, FETCH, PRESENT, DONE);
  - ADDR_W/DATA_W defaults;
  - END_MARK constant.
- Single flat module with one FSM plus address and count registers. No sub-module is needed.
- The bench instantiates the real `cola_destinos_externos` as the table.

## Test plan
- Table {0x000A0B, 0x001234, 0x000000}; `start` with `dest_ready` held at 1:
  - `dest_data` is 0x000A0B, then 0x001234;
  - `dest_valid` rises at n+2 and n+4;
  - `done` at n+6 with `count`=2.
- Same table, `dest_ready` low for 5 cycles after the first `dest_valid`:
  - `dest_data` stays 0x000A0B and `address` stays 0 throughout the stall;
  - dispatch resumes on `dest_ready`.
- Entry 0 = 0: `start` gives `done` at n+2, `count`=0, and `dest_valid` stays 0.
- All 256 entries nonzero, `dest_ready`=1:
  - exactly 256 handshakes, `count`=256;
  - `address` stops at 255 and then returns to 0;
  - exactly one `done` pulse.
- `abort` in PRESENT after 1 accept:
  - IDLE next cycle, no `done`, `count`=1;
  - a new `start` re-runs from address 0.
- `rst` asserted in FETCH, plus `start` pulsed while busy:
  - `rst` restores all reset values;
  - the `start` pulsed while busy has no effect.
